// File: rtl/srl_delay_line_if.sv
// Bundle of the delay-line control, sample and status signals shared by the driver and the line.
// master drives push/flush/data/delay and observes the delayed output and occupancy.
interface srl_delay_line_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             push;
  logic [WIDTH-1:0] data_i;
  logic [AW-1:0]    delay;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic [CW-1:0]    fill_cnt;
  logic             primed;

  modport master (
    output flush, push, data_i, delay,
    input  data_o, valid_o, fill_cnt, primed
  );

  modport slave (
    input  flush, push, data_i, delay,
    output data_o, valid_o, fill_cnt, primed
  );
endinterface

// File: rtl/srl_delay_line.sv
// Programmable tap delay line (D = delay+1 pushes) with registered output one clk after each push.
// No backpressure: every push is accepted; valid_o only qualifies samples once D samples are held.
module srl_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic            clk,
  input  logic            reset,
  srl_delay_line_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Storage carries no reset and only one read tap so it maps onto shift-register primitives.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic [CW-1:0]    fill_q;
  logic [CW-1:0]    dly_n;
  logic             have_d;

  assign dly_n  = CW'(bus.delay) + CW'(1);
  assign have_d = (fill_q >= dly_n);

  always_ff @(posedge clk) begin
    if (bus.push) begin
      mem[0] <= bus.data_i;
      for (int k = 1; k < DEPTH; k++) begin
        mem[k] <= mem[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fill_q  <= '0;
    end else if (bus.push) begin
      // Tap reads pre-shift contents: index delay is the sample pushed D pushes ago.
      data_q  <= mem[bus.delay];
      valid_q <= have_d && !bus.flush;
      if (bus.flush) begin
        fill_q <= CW'(1);
      end else if (fill_q != CW'(DEPTH)) begin
        fill_q <= fill_q + CW'(1);
      end
    end else begin
      valid_q <= 1'b0;
      if (bus.flush) begin
        fill_q <= '0;
      end
    end
  end

  assign bus.data_o   = data_q;
  assign bus.valid_o  = valid_q;
  assign bus.fill_cnt = fill_q;
  assign bus.primed   = have_d;
endmodule

// File: tb/tb_srl_delay_line.sv
// Directed and randomized checks of srl_delay_line against a push-history reference model.
module tb_srl_delay_line;
  localparam int W = 8;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  srl_delay_line_if #(.WIDTH(W), .DEPTH(N)) bus ();

  srl_delay_line #(.WIDTH(W), .DEPTH(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: every sample ever pushed (storage survives flush/reset), plus occupancy.
  logic [W-1:0] hist[$];
  int           cnt = 0;
  bit           ev = 1'b0;
  logic [W-1:0] ed = '0;
  bit           known = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'(ev));
    chk({tag, ".fill"}, 32'(bus.fill_cnt), 32'(cnt));
    if (known) chk({tag, ".data"}, 32'(bus.data_o), 32'(ed));
  endtask

  // Called at a negedge: drive, check primed, model the coming edge, check after it.
  task automatic cyc(input string tag, input bit p, input bit f, input logic [W-1:0] d, input int dl);
    int dd;
    bus.push   = p;
    bus.flush  = f;
    bus.data_i = d;
    bus.delay  = 4'(dl);
    dd = dl + 1;
    #1;
    chk({tag, ".primed"}, 32'(bus.primed), 32'(cnt >= dd));
    if (p) begin
      if (hist.size() >= dd) begin
        ed    = hist[hist.size() - dd];
        known = 1'b1;
      end else begin
        known = 1'b0;
      end
      ev  = !f && (cnt >= dd);
      cnt = f ? 1 : ((cnt < N) ? cnt + 1 : N);
      hist.push_back(d);
    end else begin
      ev = 1'b0;
      if (f) cnt = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Reset raised between edges; occupancy must clear before the next clock edge.
  task automatic mid_reset(input string tag);
    bus.push  = 1'b0;
    bus.flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    cnt = 0; ev = 1'b0; ed = '0; known = 1'b1;
    check_outputs({tag, ".async"});
    chk({tag, ".primed"}, 32'(bus.primed), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit           p, f;
    int           dl;
    logic [W-1:0] seed;
    bus.push = 1'b0; bus.flush = 1'b0; bus.data_i = '0; bus.delay = '0;
    #1 reset = 1'b1;
    bus.delay = 4'($urandom_range(0, 15));
    @(negedge clk);
    check_outputs("reset");
    chk("reset.primed", 32'(bus.primed), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fixed delay D=4, ramp data 1..10
    for (int i = 1; i <= 10; i++) cyc("d4ramp", 1'b1, 1'b0, W'(i), 3);
    chk("d4ramp.last", 32'(bus.data_o), 32'd6);

    // Saturation with D=16
    mid_reset("sat.rst");
    for (int i = 0; i < 20; i++) cyc("sat", 1'b1, 1'b0, W'(i), 15);
    chk("sat.last", 32'(bus.data_o), 32'h03);
    chk("sat.fill", 32'(bus.fill_cnt), 32'd16);

    // Gapped pushes with D=2
    seed = W'($urandom);
    for (int i = 0; i < 16; i++) cyc("gap", (i % 2) == 0, 1'b0, seed + W'(i), 1);

    // Flush together with push at fill 8, D=4
    mid_reset("fl.rst");
    for (int i = 0; i < 8; i++) cyc("fl.pre", 1'b1, 1'b0, W'($urandom), 3);
    cyc("fl.push", 1'b1, 1'b1, 8'hA5, 3);
    chk("fl.fill1", 32'(bus.fill_cnt), 32'd1);
    for (int i = 0; i < 4; i++) cyc("fl.post", 1'b1, 1'b0, W'($urandom), 3);
    chk("fl.oldest", 32'(bus.data_o), 32'hA5);
    cyc("fl.idle", 1'b0, 1'b1, 8'h00, 3);

    // Delay raised past occupancy: 1 -> 7 at fill 5
    mid_reset("dl.rst");
    for (int i = 0; i < 5; i++) cyc("dl.pre", 1'b1, 1'b0, W'($urandom), 1);
    for (int i = 0; i < 5; i++) cyc("dl.post", 1'b1, 1'b0, W'($urandom), 7);

    // Asynchronous reset at fill 10 with valid_o high, then D=1
    mid_reset("ar.clr");
    for (int i = 0; i < 10; i++) cyc("ar.pre", 1'b1, 1'b0, W'($urandom), 0);
    mid_reset("ar.mid");
    cyc("ar.first", 1'b1, 1'b0, W'($urandom), 0);
    cyc("ar.second", 1'b1, 1'b0, W'($urandom), 0);

    // Randomized traffic with occasional flush, delay changes and resets
    dl = 5;
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) dl = $urandom_range(0, 15);
      if ($urandom_range(0, 99) == 0) mid_reset("rnd.rst");
      else cyc("rnd", p, f, W'($urandom), dl);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/srl_delay_line.md
SRL_DELAY_LINE -- requirements
Module: srl_delay_line

Interface
REQ-001 Parameter WIDTH, default 32: data bit width per sample.
REQ-002 Parameter DEPTH, default 128: storage depth in samples; SHALL be a power of two, >= 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port flush, input, 1 bit: synchronous clear of occupancy tracking.
REQ-006 Port push, input, 1 bit: shift enable; one sample accepted per cycle when high.
REQ-007 Port data_i, input, WIDTH bits: sample written on push.
REQ-008 Port delay, input, $clog2(DEPTH) bits: tap select; value d means delay D = d+1 pushes.
REQ-009 Port data_o, output, WIDTH bits: registered delayed sample.
REQ-010 Port valid_o, output, 1 bit: one-cycle strobe qualifying data_o.
REQ-011 Port fill_cnt, output, $clog2(DEPTH+1) bits: number of valid samples held, saturating at DEPTH.
REQ-012 Port primed, output, 1 bit: combinational; high when fill_cnt >= D for the current delay.

Function
REQ-013 Storage: shift register mem[0..DEPTH-1]; on push, mem[0] <= data_i and mem[k] <= mem[k-1] for k >= 1; no change without push.
REQ-014 On a push cycle, data_o <= mem[D-1] using pre-shift contents, i.e. the sample pushed exactly D pushes before the current one.
REQ-015 On a push cycle, valid_o <= 1 iff pre-push fill_cnt >= D; otherwise valid_o <= 0 and data_o is still updated.
REQ-016 On a non-push cycle, valid_o <= 0 and data_o holds its value.
REQ-017 Latency: data_o/valid_o appear one clk after the push edge that produced them.
REQ-018 fill_cnt: +1 per push while below DEPTH; holds at DEPTH on further pushes, and the oldest sample is discarded silently.
REQ-019 delay is sampled every push cycle; a delay change takes effect on the next push, with no state reset; primed follows delay combinationally.
REQ-020 Delay increased beyond fill_cnt: subsequent pushes produce valid_o = 0 until fill_cnt >= new D.
REQ-021 Flush without push: fill_cnt <= 0, valid_o <= 0; mem and data_o unchanged.
REQ-022 Flush with push: shift performed, fill_cnt <= 1, valid_o <= 0 (flush has priority over the output qualification).
REQ-023 D = DEPTH with fill_cnt = DEPTH: valid_o = 1 with data_o = the oldest stored sample.
REQ-024 mem SHALL have no reset and no read port other than the single tap, so that synthesis infers SRL primitives.

Reset
REQ-025 While reset is high: fill_cnt = 0, valid_o = 0, data_o = 0, primed = 0 (for any delay); mem is unaffected.
REQ-026 Reset asserted mid-stream discards occupancy immediately (asynchronously); the first push after release behaves as on an empty line.
REQ-027 Release is synchronised externally; no push is required in the first cycle after release.

Verification (WIDTH=8, DEPTH=16)
REQ-028 delay=3 (D=4), push 1..10 on consecutive cycles -> valid_o low for pushes 1-4; pushes 5..10 give data_o 1..6, each one cycle after its push edge.
REQ-029 delay=15, push 20 samples 0x00..0x13 -> fill_cnt saturates at 16; push 17 outputs 0x00 with valid_o=1; push 20 outputs 0x03.
REQ-030 Gapped push (push high on every other cycle), D=2 -> valid_o strobes only one cycle after push edges; data_o holds during gaps; sequence is unaffected by gaps.
REQ-031 fill_cnt=8, D=4, assert flush together with push -> fill_cnt=1, valid_o=0; next 3 pushes give valid_o=0; the 4th gives valid_o=1 with the flush-cycle sample.
REQ-032 fill_cnt=5, change delay from 1 to 7 -> primed drops in the same cycle; valid_o resumes on the push made when fill_cnt=8.
REQ-033 Assert reset asynchronously between clock edges while fill_cnt=10 -> fill_cnt and valid_o go to 0 before the next edge; after release, D=1 gives valid_o on the second push only.
